// File: rtl/systolic_result_collector_pkg.sv
// Shared types and constants for the systolic result collector and its row buffer.
package systolic_result_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Element width shared with the upstream systolic array.
    localparam int SRC_DATA_WIDTH = 32;

    // Lane k of a packed row occupies [lane_lsb(k,w) +: w].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/result_row_buffer.sv
// M-row register file: one full-row write port, one element read port (row, col).
module result_row_buffer
    import systolic_result_collector_pkg::*;
#(
    parameter int M          = 5,
    parameter int K          = 4,
    parameter int DATA_WIDTH = SRC_DATA_WIDTH,
    parameter int ROW_W      = (M > 1) ? $clog2(M) : 1,
    parameter int COL_W      = (K > 1) ? $clog2(K) : 1
)(
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [ROW_W-1:0]        i_wr_row,
    input  logic [DATA_WIDTH*K-1:0] i_wr_data,
    input  logic [ROW_W-1:0]        i_rd_row,
    input  logic [COL_W-1:0]        i_rd_col,
    output logic [DATA_WIDTH-1:0]   o_rd_data
);

    logic [DATA_WIDTH*K-1:0] r_mem [M];
    logic [DATA_WIDTH*K-1:0] w_row;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_row] <= i_wr_data;
        end
    end

    assign w_row     = r_mem[i_rd_row];
    assign o_rd_data = w_row[lane_lsb(int'(i_rd_col), DATA_WIDTH) +: DATA_WIDTH];

endmodule

// File: rtl/systolic_result_collector.sv
// Captures de-skewed systolic array rows (optional ReLU) and drains them row-major
// as a registered valid/ready element stream with linear addresses.
module systolic_result_collector
    import systolic_result_collector_pkg::*;
#(
    parameter int M          = 5,
    parameter int K          = 4,
    parameter int DATA_WIDTH = SRC_DATA_WIDTH,
    parameter bit RELU_EN    = 1'b0,
    parameter int ADDR_WIDTH = $clog2(M*K) + 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH*K-1:0] y_in,
    input  logic                    y_valid,
    input  logic                    y_done,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    short_err
);

    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int CNT_W = $clog2(M + 1);
    localparam int COL_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(M - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(K - 1);

    state_t                  r_state, w_next;
    logic [CNT_W-1:0]        r_row, r_limit;
    logic [COL_W-1:0]        r_col;
    logic                    r_out_valid, r_busy, r_done, r_short_err;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [ADDR_WIDTH-1:0]   r_out_addr;

    logic                    w_xfer, w_last_elem, w_cap_last, w_short, w_load, w_wr_en;
    logic [CNT_W-1:0]        w_rd_row;
    logic [COL_W-1:0]        w_rd_col;
    logic [DATA_WIDTH*K-1:0] w_relu_row;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    assign w_xfer      = r_out_valid && out_ready;
    assign w_last_elem = (r_row == r_limit - CNT_W'(1)) && (r_col == COL_MAX);
    assign w_cap_last  = y_valid && (r_row == ROW_MAX);
    assign w_short     = !y_valid && y_done;
    assign w_wr_en     = (r_state == ST_CAPTURE) && y_valid;
    // Reload the output register on the first drain cycle and on every non-final transfer.
    assign w_load      = (r_state == ST_DRAIN) && (!r_out_valid || (w_xfer && !w_last_elem));

    always_comb begin
        w_rd_row = r_row;
        w_rd_col = r_col;
        if (w_xfer) begin
            if (r_col == COL_MAX) begin
                w_rd_col = '0;
                w_rd_row = r_row + CNT_W'(1);
            end else begin
                w_rd_col = r_col + COL_W'(1);
            end
        end
    end

    always_comb begin
        w_relu_row = y_in;
        if (RELU_EN) begin
            for (int k = 0; k < K; k++) begin
                if (y_in[lane_lsb(k, DATA_WIDTH) + DATA_WIDTH - 1]) begin
                    w_relu_row[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = '0;
                end
            end
        end
    end

    result_row_buffer #(
        .M          (M),
        .K          (K),
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_row  (r_row[ROW_W-1:0]),
        .i_wr_data (w_relu_row),
        .i_rd_row  (w_rd_row[ROW_W-1:0]),
        .i_rd_col  (w_rd_col),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (w_cap_last) begin
                    w_next = ST_DRAIN;
                end else if (w_short) begin
                    w_next = (r_row == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN:   if (w_xfer && w_last_elem) w_next = ST_DONE;
            ST_DONE:    if (start) w_next = ST_CAPTURE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row       <= '0;
            r_col       <= '0;
            r_limit     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_short_err <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_CAPTURE) || (w_next == ST_DRAIN);
            r_done <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_row       <= '0;
                        r_col       <= '0;
                        r_short_err <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    r_col <= '0;
                    if (y_valid) begin
                        if (w_cap_last) begin
                            r_row   <= '0;
                            r_limit <= CNT_W'(M);
                        end else begin
                            r_row <= r_row + CNT_W'(1);
                        end
                    end else if (y_done) begin
                        r_short_err <= 1'b1;
                        r_limit     <= r_row;
                        r_row       <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_rd_data;
                        r_out_addr  <= ADDR_WIDTH'(int'(w_rd_row) * K + int'(w_rd_col));
                        r_row       <= w_rd_row;
                        r_col       <= w_rd_col;
                    end else if (w_xfer) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign short_err = r_short_err;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Scoreboard bench: plain and ReLU instances share stimulus; a negedge monitor pops expected beats.
module tb_systolic_result_collector;

    localparam int M  = 5;
    localparam int K  = 4;
    localparam int DW = 32;
    localparam int AW = $clog2(M*K) + 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, y_valid, y_done, out_ready;
    logic [DW*K-1:0] y_in;

    logic [DW-1:0] o0_data, o1_data;
    logic [AW-1:0] o0_addr, o1_addr;
    logic o0_valid, o0_busy, o0_done, o0_serr;
    logic o1_valid, o1_busy, o1_done, o1_serr;

    exp_t exp0[$];
    exp_t exp1[$];
    logic [DW-1:0] tbl [M][K];
    int checks = 0;
    int failures = 0;
    int xfer0 = 0;

    always #5 clk = ~clk;

    systolic_result_collector #(.M(M), .K(K), .DATA_WIDTH(DW), .RELU_EN(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .y_in(y_in), .y_valid(y_valid), .y_done(y_done),
        .out_data(o0_data), .out_addr(o0_addr), .out_valid(o0_valid), .out_ready(out_ready),
        .busy(o0_busy), .done(o0_done), .short_err(o0_serr));

    systolic_result_collector #(.M(M), .K(K), .DATA_WIDTH(DW), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .y_in(y_in), .y_valid(y_valid), .y_done(y_done),
        .out_data(o1_data), .out_addr(o1_addr), .out_valid(o1_valid), .out_ready(out_ready),
        .busy(o1_busy), .done(o1_done), .short_err(o1_serr));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        xfer0 = 0;
        check("start_busy", o0_busy, 1);
        check("start_done_clr", o0_done | o1_done, 0);
        check("start_serr_clr", o0_serr | o1_serr, 0);
    endtask

    task automatic send_rows(input int first, input int last, input int gap, input bit keep);
        for (int r = first; r <= last; r++) begin
            for (int k = 0; k < K; k++) begin
                y_in[DW*k +: DW] = tbl[r][k];
                exp0.push_back('{d: tbl[r][k], a: AW'(r*K + k)});
                exp1.push_back('{d: relu(tbl[r][k]), a: AW'(r*K + k)});
            end
            y_valid = 1'b1;
            tick();
            if (gap > 0) begin
                y_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        y_valid = keep;
    endtask

    task automatic wait_done(input int nbeats, input bit serr, input logic [3:0] pat, input int budget);
        int cyc = 0;
        while (!(o0_done && o1_done) && cyc < budget) begin
            out_ready = pat[cyc % 4];
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check("job_done", o0_done && o1_done, 1);
        check("busy_low_at_done", o0_busy | o1_busy, 0);
        check("valid_low_at_done", o0_valid | o1_valid, 0);
        check("short_err_plain", o0_serr, serr);
        check("short_err_relu", o1_serr, serr);
        check("beat_count", xfer0, nbeats);
        check("queue_drained", exp0.size() + exp1.size(), 0);
    endtask

    // Monitor: compares every transfer against the scoreboard and checks hold-under-stall.
    initial begin
        bit stall = 1'b0;
        logic [DW-1:0] hold_d;
        logic [AW-1:0] hold_a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_valid_held", o0_valid, 1);
                    check("stall_data_held", o0_data, hold_d);
                    check("stall_addr_held", o0_addr, hold_a);
                end
                stall  = o0_valid && !out_ready;
                hold_d = o0_data;
                hold_a = o0_addr;
                if (o0_valid && out_ready) begin
                    check("plain_beat_expected", exp0.size() != 0, 1);
                    if (exp0.size() != 0) begin
                        e = exp0.pop_front();
                        check("plain_data", o0_data, e.d);
                        check("plain_addr", o0_addr, e.a);
                    end
                    xfer0++;
                end
                if (o1_valid && out_ready) begin
                    check("relu_beat_expected", exp1.size() != 0, 1);
                    if (exp1.size() != 0) begin
                        e = exp1.pop_front();
                        check("relu_data", o1_data, e.d);
                        check("relu_addr", o1_addr, e.a);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; y_in = '0; y_valid = 1'b0; y_done = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o0_valid | o1_valid, 0);
        check("rst_data", o0_data, 0);
        check("rst_addr", o0_addr, 0);
        check("rst_busy", o0_busy | o1_busy, 0);
        check("rst_done", o0_done | o1_done, 0);
        check("rst_serr", o0_serr | o1_serr, 0);
        rst = 1'b0;
        tick();

        // Nominal: lane k of row r = 100*r+k, y_valid left high after the last row.
        for (int r = 0; r < M; r++)
            for (int k = 0; k < K; k++) tbl[r][k] = DW'(100*r + k);
        pulse_start();
        send_rows(0, M-1, 0, 1'b1);
        check("latency_not_yet", o0_valid, 0);
        tick();
        check("latency_first_valid", o0_valid, 1);
        wait_done(M*K, 1'b0, 4'b1111, 200);
        y_valid = 1'b0;

        // Backpressure: ready pattern 1,0,0,1.
        pulse_start();
        send_rows(0, M-1, 0, 1'b0);
        wait_done(M*K, 1'b0, 4'b1001, 400);

        // Negative and boundary values through both instances.
        tbl[0][0] = 32'hFFFF_FFFF; tbl[0][1] = 32'd5;
        tbl[0][2] = 32'h8000_0000; tbl[0][3] = 32'h7FFF_FFFF;
        tbl[2][1] = 32'hFFFF_FFF9; tbl[4][3] = 32'hC000_0001;
        pulse_start();
        send_rows(0, M-1, 0, 1'b0);
        wait_done(M*K, 1'b0, 4'b1111, 200);

        // Gapped capture: two idle cycles between valid beats.
        for (int r = 0; r < M; r++)
            for (int k = 0; k < K; k++) tbl[r][k] = DW'(32'h1000_0000 + 16*r + k);
        pulse_start();
        send_rows(0, M-1, 2, 1'b0);
        wait_done(M*K, 1'b0, 4'b1111, 300);

        // Short job: y_done after 3 rows.
        pulse_start();
        send_rows(0, 2, 0, 1'b0);
        y_done = 1'b1;
        tick();
        y_done = 1'b0;
        wait_done(3*K, 1'b1, 4'b1111, 200);

        // Degenerate short job: y_done before any row.
        pulse_start();
        y_done = 1'b1;
        tick();
        y_done = 1'b0;
        wait_done(0, 1'b1, 4'b1111, 50);

        // Reset in the middle of a drain after 7 transfers.
        pulse_start();
        send_rows(0, M-1, 0, 1'b0);
        for (int i = 0; i < 60 && xfer0 < 7; i++) tick();
        check("xfers_before_reset", xfer0, 7);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", o0_valid | o1_valid, 0);
        check("midrst_busy", o0_busy | o1_busy, 0);
        check("midrst_done", o0_done, 0);
        exp0.delete();
        exp1.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Clean job after reset, with a start pulse inside CAPTURE that must be ignored.
        for (int r = 0; r < M; r++)
            for (int k = 0; k < K; k++) tbl[r][k] = DW'(7000 + 10*r + k);
        pulse_start();
        send_rows(0, 1, 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_rows(2, M-1, 0, 1'b0);
        wait_done(M*K, 1'b0, 4'b1111, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Sits directly downstream of the weight-stationary systolic array.
- Captures the M de-skewed output rows (K lanes of DATA_WIDTH each) that the array presents on its valid beats, with optional ReLU.
- Buffers the rows, then drains them as a row-major, one-element-per-beat valid/ready stream with linear addresses toward the result memory/writeback stage.

Parameters:
- M, 5, number of output rows (matrix rows) per job
- K, 4, number of output lanes (columns) per row
- DATA_WIDTH, 32, element width, two's complement
- RELU_EN, 0, 1 = clamp negative elements to 0 on capture
- ADDR_WIDTH, $clog2(M*K)+1, width of out_addr

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; arms a new job
- y_in  in  DATA_WIDTH*K  array output row; lane k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
- y_valid  in  1  array output valid; may stay high after the last row
- y_done  in  1  array finished flag (level)
- out_data  out  DATA_WIDTH  drained element
- out_addr  out  ADDR_WIDTH  linear address r*K+c
- out_valid  out  1  drain beat valid
- out_ready  in  1  consumer ready
- busy  out  1  high in CAPTURE or DRAIN
- done  out  1  high in DONE until next start
- short_err  out  1  sticky: y_done seen with fewer than M rows captured; cleared by start

Behaviour:
- Reset (async): state=IDLE; out_valid=0, out_data=0, out_addr=0, busy=0, done=0, short_err=0. Row and column counters are 0. Buffer contents are don't-care.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: start -> CAPTURE, row counter r=0.
- DONE: start -> CAPTURE, r=0, done=0, short_err=0.
- start in CAPTURE or DRAIN is ignored.
- CAPTURE:
  - Each cycle with y_valid=1 writes y_in into buffer row r (ReLU applied per lane if RELU_EN), then r++.
  - When the write of row M-1 occurs -> DRAIN next cycle.
  - y_done=1 with y_valid=0 and r<M -> short_err=1; go to DRAIN with row limit = r.
  - y_done=1 with r=0 -> short_err=1; go directly to DONE (nothing to drain).
- DRAIN:
  - Element index (r,c) is walked row-major from (0,0).
  - out_valid=1; out_data=buf[r][c]; out_addr=r*K+c.
  - Transfer occurs when out_valid && out_ready. On transfer, advance c, wrapping to 0 with r++.
  - Without a transfer, out_data and out_addr are held stable (AXI-style rule; out_valid never drops until the transfer).
  - Transfer of the last element (row limit-1, K-1) -> DONE; out_valid=0 on the next cycle.
  - y_valid is ignored in DRAIN and DONE. Extra array beats are not errors.
- Latency: first out_valid one cycle after the capture of the last row. Full-throughput drain is M*K cycles with out_ready held high.
- Outputs are registered. No combinational path from out_ready to out_valid.
- Reset mid-job: immediate return to IDLE; partial data discarded.
- ReLU: an element with its MSB set becomes 0. Otherwise it passes unchanged. No width change.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: IDLE=0, CAPTURE=1, DRAIN=2, DONE=3)
  - a DATA_WIDTH default constant shared with the array
  - the lane-slice index helper convention
- One natural sub-module: result_row_buffer, an M-entry by DATA_WIDTH*K register file with one row write port and one element read port (row, col select), no reset on storage.

Test Plan:
- Nominal, defaults, RELU_EN=0, out_ready=1:
  - Stimulus: start, then 5 consecutive y_valid beats with row r lane k = 100*r+k; y_valid stays high after.
  - Response: 20 beats, out_addr 0..19, out_data 0,1,2,3,100,...,403; done=1; short_err=0; busy low after the last beat.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeating.
  - Response: out_data/out_addr are stable while out_valid && !out_ready; still exactly 20 transfers in order.
- ReLU, RELU_EN=1:
  - Stimulus: row 0 = {-1, 5, 0x80000000, 0x7FFFFFFF}.
  - Response: drained 0, 5, 0, 0x7FFFFFFF.
- Gapped valid and short job:
  - Gapped: y_valid with gaps of 2 idle cycles captures correctly.
  - Short: y_done after 3 rows -> short_err=1; 12 drain beats, addr 0..11; done=1.
- Reset and start edge cases:
  - rst asserted mid-DRAIN at beat 7 -> out_valid=0, busy=0 immediately; next start runs a clean 20-beat job.
  - start during CAPTURE is ignored, and row count is unaffected.
